// File: rtl/half_exp2_arb_pkg.sv
// ============================================================================
// half_exp2_arb_pkg : shared constants and helpers for the exp2 arbiter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package half_exp2_arb_pkg;

  localparam int HALF_W        = 16;
  localparam logic [HALF_W-1:0] HALF_ONE = 16'h3C00;

  localparam int NREQ_DEFAULT  = 4;
  localparam int DEPTH_DEFAULT = 64;

  // A single requester still needs a one-bit tag to keep the FIFO non-degenerate.
  function automatic int tag_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/half_exp2_arbiter_tag_fifo.sv
// ============================================================================
// arb_tag_fifo : synchronous show-ahead FIFO holding requester tags in flight
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_tag_fifo
  import half_exp2_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/half_exp2_arbiter.sv
// ============================================================================
// half_exp2_arbiter : round-robin sharing of one half-precision exp2 pipeline
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module half_exp2_arbiter
  import half_exp2_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int W     = HALF_W
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*W-1:0]          req_a,
  output logic [NREQ-1:0]            req_ready,
  output logic                       exp_in_valid,
  output logic [W-1:0]               exp_a,
  input  logic                       exp_out_valid,
  input  logic [W-1:0]               exp_c,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [W-1:0]               rsp_c,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err_orphan
);

  localparam int TAG_W = tag_w(NREQ);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             exp_in_valid_q, exp_in_valid_d;
  logic [W-1:0]     exp_a_q, exp_a_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_c_q, rsp_c_d;
  logic             err_orphan_q, err_orphan_d;

  logic [TAG_W-1:0] winner;
  logic [TAG_W-1:0] rr_next;
  logic [W-1:0]     win_a;
  logic             found;
  logic             grant_ok;
  logic             push;
  logic             pop;

  logic [TAG_W-1:0] fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        found  = 1'b1;
        winner = TAG_W'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  // rstn gating keeps req_ready low while reset is held, like every other output.
  assign grant_ok = found & ~fifo_full & rstn;
  assign push     = grant_ok;
  assign pop      = exp_out_valid & ~fifo_empty;
  assign win_a    = req_a[int'(winner)*W +: W];
  assign rr_next  = (int'(winner) == NREQ-1) ? '0 : winner + TAG_W'(1);

  always_comb begin
    req_ready = '0;
    if (grant_ok) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    exp_in_valid_d = push;
    exp_a_d        = exp_a_q;
    rsp_valid_d    = '0;
    rsp_c_d        = rsp_c_q;
    err_orphan_d   = err_orphan_q | (exp_out_valid & fifo_empty);
    if (push) begin
      rr_ptr_d = rr_next;
      exp_a_d  = win_a;
    end
    if (pop) begin
      rsp_valid_d[fifo_dout] = 1'b1;
      rsp_c_d                = exp_c;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q       <= '0;
      exp_in_valid_q <= 1'b0;
      exp_a_q        <= '0;
      rsp_valid_q    <= '0;
      rsp_c_q        <= '0;
      err_orphan_q   <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      exp_in_valid_q <= exp_in_valid_d;
      exp_a_q        <= exp_a_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_c_q        <= rsp_c_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  arb_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (winner),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign exp_in_valid = exp_in_valid_q;
  assign exp_a        = exp_a_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_c        = rsp_c_q;
  assign outstanding  = fifo_count;
  assign err_orphan   = err_orphan_q;

endmodule

`default_nettype wire
